// File: rtl/seven_segment_reader.sv
// Receive side of a multiplexed 7-segment display bus: filters glitches on the sampled
// segment/select lines, decodes each digit back to BCD and hands out complete frames.
module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     dig_sel,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [4*NUM_DIGITS-1:0]   frame_data,
  output logic                      frame_err,
  output logic [NUM_DIGITS-1:0]     live_mask
);

  localparam int SW = 8 + NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 2);
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES + 1);

  typedef enum logic {COLLECT, PRESENT} state_t;

  // Handshake: a frame transfers on every rising edge where frame_valid & frame_ready;
  // frame_data/frame_err never change while frame_valid is high and not yet accepted.

  state_t                          state_q, state_d;
  logic [SW-1:0]                   prev_q, prev_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]      live_q, live_d;
  logic [NUM_DIGITS-1:0]           mask_q, mask_d;
  logic                            err_q, err_d;
  logic [4*NUM_DIGITS-1:0]         frame_data_q;
  logic                            frame_err_q;

  logic [3:0] code;
  logic       sel_ok;
  logic       strobe;
  logic       load_frame;
  logic       accept;

  always_comb begin
    case (seg_in)
      8'h3F:   code = 4'h0;
      8'h06:   code = 4'h1;
      8'h5B:   code = 4'h2;
      8'h4F:   code = 4'h3;
      8'h66:   code = 4'h4;
      8'h6D:   code = 4'h5;
      8'h7D:   code = 4'h6;
      8'h07:   code = 4'h7;
      8'h7F:   code = 4'h8;
      8'h6F:   code = 4'h9;
      8'h80:   code = 4'hE;
      default: code = 4'hF;
    endcase
  end

  // Run length of identical samples; saturates one past the hit value so the
  // capture strobe fires once per stable episode.
  always_comb begin
    prev_d = {seg_in, dig_sel};
    sel_ok = $onehot(dig_sel);
    if (!sel_ok) begin
      cnt_d = '0;
    end else if (prev_d != prev_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    strobe = sel_ok && (cnt_d == CNT_HIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (&mask_q)     state_d = PRESENT;
      PRESENT: if (frame_ready) state_d = COLLECT;
      default:                  state_d = COLLECT;
    endcase
  end

  always_comb begin
    frame_valid = (state_q == PRESENT);
    load_frame  = (state_q == COLLECT) && (&mask_q);
    accept      = (state_q == PRESENT) && frame_ready;
  end

  // An accepted frame clears the accumulators before a same-edge capture is merged in.
  always_comb begin
    live_d = live_q;
    mask_d = accept ? '0 : mask_q;
    err_d  = accept ? 1'b0 : err_q;
    if (strobe) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_sel[i]) live_d[i] = code;
      end
      mask_d = mask_d | dig_sel;
      err_d  = err_d | (code == 4'hF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= '0;
      cnt_q        <= '0;
      live_q       <= '0;
      mask_q       <= '0;
      err_q        <= 1'b0;
      frame_data_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      live_q <= live_d;
      mask_q <= mask_d;
      err_q  <= err_d;
      if (load_frame) begin
        frame_data_q <= live_d;
        frame_err_q  <= err_d;
      end
    end
  end

  assign frame_data = frame_data_q;
  assign frame_err  = frame_err_q;
  assign live_mask  = mask_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: directed scenarios plus random scanning, checked by a
// sample-history reference model feeding an expected-frame queue.
module tb_seven_segment_reader;

  localparam int ND = 4;
  localparam int SC = 3;
  localparam int DW = 4 * ND;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic          frame_valid;
  logic          frame_ready;
  logic [DW-1:0] frame_data;
  logic          frame_err;
  logic [ND-1:0] live_mask;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;

  logic [DW:0] exp_q[$];

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .live_mask   (live_mask)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_decode(input logic [7:0] s);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return 4'(i);
    if (s == 8'h80) return 4'hE;
    return 4'hF;
  endfunction

  logic [ND+7:0] hist[$];
  logic [3:0]    m_live [ND];
  logic [ND-1:0] m_mask;
  logic          m_err;
  logic          m_present;
  logic [DW-1:0] m_fdata;
  logic          m_ferr;

  always @(posedge clk) begin : model
    logic [ND+7:0] sample;
    int            run;
    bit            cap;
    logic [3:0]    c;
    logic [3:0]    nl [ND];
    logic [ND-1:0] capbit;
    logic          caperr;
    logic [DW-1:0] packed_live;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < ND; i++) m_live[i] = 4'h0;
      m_mask = '0; m_err = 1'b0; m_present = 1'b0; m_fdata = '0; m_ferr = 1'b0;
    end else begin
      sample = {seg_in, dig_sel};
      hist.push_back(sample);
      if (hist.size() > SC + 1) void'(hist.pop_front());
      run = 0;
      for (int j = hist.size() - 1; j >= 0; j--) begin
        if (hist[j] == sample) run++;
        else break;
      end
      cap    = ($countones(dig_sel) == 1) && (run == SC);
      c      = ref_decode(seg_in);
      capbit = cap ? dig_sel : '0;
      caperr = cap && (c == 4'hF);
      for (int i = 0; i < ND; i++) nl[i] = (cap && dig_sel[i]) ? c : m_live[i];
      for (int i = 0; i < ND; i++) packed_live[4*i +: 4] = nl[i];
      if (!m_present) begin
        if (m_mask == '1) begin
          m_present = 1'b1;
          m_fdata   = packed_live;
          m_ferr    = m_err | caperr;
          exp_q.push_back({m_ferr, m_fdata});
        end
        m_mask = m_mask | capbit;
        m_err  = m_err | caperr;
      end else if (frame_ready) begin
        m_present = 1'b0;
        m_mask    = capbit;
        m_err     = caperr;
      end else begin
        m_mask = m_mask | capbit;
        m_err  = m_err | caperr;
      end
      for (int i = 0; i < ND; i++) m_live[i] = nl[i];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin : monitor
    logic [DW:0] e;
    if (mon_en) begin
      n_checks++;
      if (frame_valid !== m_present) begin
        n_errors++;
        $display("FAIL valid_track: got %b want %b at %0t", frame_valid, m_present, $time);
      end
      n_checks++;
      if (live_mask !== m_mask) begin
        n_errors++;
        $display("FAIL live_mask_track: got %b want %b at %0t", live_mask, m_mask, $time);
      end
      if (frame_valid === 1'b1 && m_present) begin
        n_checks++;
        if ({frame_err, frame_data} !== {m_ferr, m_fdata}) begin
          n_errors++;
          $display("FAIL frame_hold: got %b/%h want %b/%h at %0t",
                   frame_err, frame_data, m_ferr, m_fdata, $time);
        end
      end
      if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL frame_accept: got %b/%h want nothing (queue empty) at %0t",
                   frame_err, frame_data, $time);
        end else begin
          e = exp_q.pop_front();
          if ({frame_err, frame_data} !== e) begin
            n_errors++;
            $display("FAIL frame_accept: got %b/%h want %b/%h at %0t",
                     frame_err, frame_data, e[DW], e[DW-1:0], $time);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) frame_ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic show(input logic [7:0] s, input logic [ND-1:0] d, input int n);
    seg_in  = s;
    dig_sel = d;
    repeat (n) tick();
  endtask

  task automatic accept_frame();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [ND-1:0] sel;
    logic [7:0]    s;
    int            r;
    rst = 1'b1; seg_in = 8'h00; dig_sel = '0; frame_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // reset in the middle of a capture
    show(8'h3F, 4'b0001, 5);
    show(8'h06, 4'b0010, 2);
    rst = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_data",  32'(frame_data),  32'd0);
    chk("rst_err",   32'(frame_err),   32'd0);
    chk("rst_mask",  32'(live_mask),   32'd0);
    rst = 1'b0;

    // clean scan
    show(8'h4F, 4'b0001, 5);
    show(8'h66, 4'b0010, 5);
    show(8'h6D, 4'b0100, 5);
    show(8'h7D, 4'b1000, 5);
    chk("scan_valid", 32'(frame_valid), 32'd1);
    chk("scan_data",  32'(frame_data),  32'h6543);
    chk("scan_err",   32'(frame_err),   32'd0);
    tick();
    chk("scan_hold", 32'(frame_valid), 32'd1);
    accept_frame();
    chk("scan_drop", 32'(frame_valid), 32'd0);

    // 2-cycle glitch on digit 1 must not be captured
    show(8'h3F, 4'b0001, 4);
    show(8'h06, 4'b0010, 4);
    show(8'h7F, 4'b0010, 2);
    show(8'h06, 4'b0010, 4);
    show(8'h5B, 4'b0100, 4);
    show(8'h4F, 4'b1000, 4);
    chk("glitch_valid", 32'(frame_valid), 32'd1);
    chk("glitch_data",  32'(frame_data),  32'h3210);
    accept_frame();

    // invalid and blank patterns, then a clean frame clears the error
    show(8'h3F, 4'b0001, 4);
    show(8'h06, 4'b0010, 4);
    show(8'h12, 4'b0100, 4);
    show(8'h80, 4'b1000, 4);
    chk("inv_data", 32'(frame_data), 32'hEF10);
    chk("inv_err",  32'(frame_err),  32'd1);
    accept_frame();
    show(8'h07, 4'b0001, 4);
    show(8'h7F, 4'b0010, 4);
    show(8'h6F, 4'b0100, 4);
    show(8'h66, 4'b1000, 4);
    chk("clr_data", 32'(frame_data), 32'h4987);
    chk("clr_err",  32'(frame_err),  32'd0);
    accept_frame();

    // select faults: no capture
    show(8'h3F, 4'b0001, 4);
    show(8'h3F, 4'b0000, 10);
    show(8'h5B, 4'b0110, 10);
    chk("sel_fault_mask", 32'(live_mask), 32'h1);
    show(8'h06, 4'b0010, 4);
    show(8'h5B, 4'b0100, 4);
    show(8'h4F, 4'b1000, 4);
    chk("sel_fault_data", 32'(frame_data), 32'h3210);

    // accept on the same edge as a digit-0 capture
    seg_in = 8'h66; dig_sel = 4'b0001;
    tick(); tick();
    frame_ready = 1'b1;
    tick();
    chk("acc_cap_valid", 32'(frame_valid), 32'd0);
    chk("acc_cap_mask",  32'(live_mask),   32'h1);
    repeat (5) tick();
    chk("ready_idle_valid", 32'(frame_valid), 32'd0);
    frame_ready = 1'b0;

    // random scanning with random back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      sel = '0;
      else if (r == 1) sel = ND'($urandom);
      else             sel = ND'(1) << $urandom_range(0, ND - 1);
      r = $urandom_range(0, 9);
      if (r < 7)       s = seg_tab[$urandom_range(0, 9)];
      else if (r == 7) s = 8'h80;
      else             s = 8'($urandom);
      show(s, sel, $urandom_range(1, 6));
    end

    // drain
    rand_ready = 1'b0;
    dig_sel = '0;
    frame_ready = 1'b1;
    repeat (8) tick();
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(frame_valid), 32'd0);
    frame_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
